// File: rtl/semafor_pkg.sv
// Shared definitions for the traffic-light controller and its monitor:
// phase encoding, error codes, lamp patterns and nominal phase durations.
package semafor_pkg;

  typedef enum logic [1:0] {
    PH_GREEN   = 2'd0,
    PH_YELLOW  = 2'd1,
    PH_RED     = 2'd2,
    PH_INVALID = 2'd3
  } phase_e;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_CONFLICT = 3'd1;
  localparam logic [2:0] ERR_SEQUENCE = 3'd2;
  localparam logic [2:0] ERR_YELLOW_T = 3'd3;
  localparam logic [2:0] ERR_RED_T    = 3'd4;

  // Nominal durations in seconds, shared with the controller.
  localparam int T_RED    = 10;
  localparam int T_GREEN  = 5;
  localparam int T_YELLOW = 2;
  localparam int T_DELAY  = 10;

  // Lamp vector order {red, yellow, green, redpieton, greenpieton}; 0 = lit.
  localparam logic [4:0] LAMPS_GREEN  = 5'b11001;
  localparam logic [4:0] LAMPS_YELLOW = 5'b10101;
  localparam logic [4:0] LAMPS_RED    = 5'b01110;

  // True when 'to' is the single permitted successor of 'from'.
  function automatic logic legal_step(input phase_e from, input phase_e to);
    case (from)
      PH_GREEN:  return to == PH_YELLOW;
      PH_YELLOW: return to == PH_RED;
      PH_RED:    return to == PH_GREEN;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/semafor_lamp_decode.sv
// Maps the registered active-low lamp vector to a traffic-light phase.
module semafor_lamp_decode
  import semafor_pkg::*;
(
  input  logic [4:0] lamps,
  output phase_e     ph
);

  // Exact pattern match; anything else is a lamp conflict.
  always_comb begin
    ph = PH_INVALID;
    case (lamps)
      LAMPS_GREEN:  ph = PH_GREEN;
      LAMPS_YELLOW: ph = PH_YELLOW;
      LAMPS_RED:    ph = PH_RED;
      default:      ph = PH_INVALID;
    endcase
  end

endmodule

// File: rtl/semafor_monitor.sv
// Traffic-light monitor: samples the lamps, decodes the phase and checks
// lamp conflicts, phase sequence and yellow/red durations.
module semafor_monitor
  import semafor_pkg::*;
#(
  parameter int T_YELLOW = semafor_pkg::T_YELLOW,
  parameter int T_RED    = semafor_pkg::T_RED,
  parameter int TOL      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        impuls,
  input  logic        red,
  input  logic        yellow,
  input  logic        green,
  input  logic        redpieton,
  input  logic        greenpieton,
  input  logic        clr_err,
  output logic [1:0]  phase,
  output logic [7:0]  phase_secs,
  output logic [15:0] cycles,
  output logic        err_conflict,
  output logic        err_sequence,
  output logic        err_timing,
  output logic [2:0]  err_code
);

  logic [4:0]  lamps_p0;
  phase_e      dec_phase;
  phase_e      phase_p1;
  logic [7:0]  secs_p1;
  logic [15:0] cycles_p1;
  logic        conf_p1, seq_p1, tim_p1;
  logic [2:0]  code_p1;

  logic        changed, red_to_green;
  logic        hit_conf, hit_seq, hit_ty, hit_tr;
  logic        conf_nxt, seq_nxt, tim_nxt;
  logic [2:0]  code_nxt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic out_of_window(input logic [7:0] v, input int nom, input int tol);
    return (int'(v) < nom - tol) || (int'(v) > nom + tol);
  endfunction

  // Stage 0: lamp sample register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lamps_p0 <= LAMPS_GREEN;
    else      lamps_p0 <= {red, yellow, green, redpieton, greenpieton};
  end

  semafor_lamp_decode u_decode (
    .lamps (lamps_p0),
    .ph    (dec_phase)
  );

  // Error detection against the previously decoded phase; INVALID on either side never counts as a sequence or timing fault.
  always_comb begin
    changed      = (dec_phase != phase_p1);
    red_to_green = changed && (phase_p1 == PH_RED) && (dec_phase == PH_GREEN);
    hit_conf     = (dec_phase == PH_INVALID);
    hit_seq      = changed && (phase_p1 != PH_INVALID) && (dec_phase != PH_INVALID)
                   && !legal_step(phase_p1, dec_phase);
    hit_ty       = changed && (phase_p1 == PH_YELLOW) && (dec_phase == PH_RED)
                   && out_of_window(secs_p1, T_YELLOW, TOL);
    hit_tr       = red_to_green && out_of_window(secs_p1, T_RED, TOL);
  end

  // Sticky flags and first-error code; a clear is applied before this cycle's detections.
  always_comb begin
    conf_nxt = clr_err ? 1'b0 : conf_p1;
    seq_nxt  = clr_err ? 1'b0 : seq_p1;
    tim_nxt  = clr_err ? 1'b0 : tim_p1;
    code_nxt = clr_err ? ERR_NONE : code_p1;
    conf_nxt = conf_nxt | hit_conf;
    seq_nxt  = seq_nxt | hit_seq;
    tim_nxt  = tim_nxt | hit_ty | hit_tr;
    if (code_nxt == ERR_NONE) begin
      if (hit_conf)     code_nxt = ERR_CONFLICT;
      else if (hit_seq) code_nxt = ERR_SEQUENCE;
      else if (hit_ty)  code_nxt = ERR_YELLOW_T;
      else if (hit_tr)  code_nxt = ERR_RED_T;
    end
  end

  // Stage 1: phase, seconds, cycle count and error state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_p1  <= PH_GREEN;
      secs_p1   <= 8'd0;
      cycles_p1 <= 16'd0;
      conf_p1   <= 1'b0;
      seq_p1    <= 1'b0;
      tim_p1    <= 1'b0;
      code_p1   <= ERR_NONE;
    end else begin
      phase_p1 <= dec_phase;
      if (changed)     secs_p1 <= 8'd0;
      else if (impuls) secs_p1 <= sat_inc8(secs_p1);
      if (red_to_green) cycles_p1 <= cycles_p1 + 16'd1;
      conf_p1 <= conf_nxt;
      seq_p1  <= seq_nxt;
      tim_p1  <= tim_nxt;
      code_p1 <= code_nxt;
    end
  end

  assign phase        = phase_p1;
  assign phase_secs   = secs_p1;
  assign cycles       = cycles_p1;
  assign err_conflict = conf_p1;
  assign err_sequence = seq_p1;
  assign err_timing   = tim_p1;
  assign err_code     = code_p1;

endmodule

// File: tb/tb_semafor_monitor.sv
// Bench for semafor_monitor: directed scenarios plus randomized phase
// sequences, every cycle compared against a behavioural model.
module tb_semafor_monitor;

  localparam int TY  = 2;
  localparam int TR  = 10;
  localparam int TOL = 1;

  localparam logic [4:0] PG    = 5'b11001;
  localparam logic [4:0] PY    = 5'b10101;
  localparam logic [4:0] PR    = 5'b01110;
  localparam logic [4:0] PCONF = 5'b11010;

  logic clk, rst, impuls, red, yellow, green, redpieton, greenpieton, clr_err;
  logic [1:0]  phase;
  logic [7:0]  phase_secs;
  logic [15:0] cycles;
  logic        err_conflict, err_sequence, err_timing;
  logic [2:0]  err_code;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int m_phase, m_secs, m_cycles, m_conf, m_seq, m_tim, m_code;
  logic [4:0] pat_prev;

  semafor_monitor #(.T_YELLOW(TY), .T_RED(TR), .TOL(TOL)) dut (
    .clk          (clk),
    .rst          (rst),
    .impuls       (impuls),
    .red          (red),
    .yellow       (yellow),
    .green        (green),
    .redpieton    (redpieton),
    .greenpieton  (greenpieton),
    .clr_err      (clr_err),
    .phase        (phase),
    .phase_secs   (phase_secs),
    .cycles       (cycles),
    .err_conflict (err_conflict),
    .err_sequence (err_sequence),
    .err_timing   (err_timing),
    .err_code     (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int phase_of(input logic [4:0] p);
    if (p == PG) return 0;
    if (p == PY) return 1;
    if (p == PR) return 2;
    return 3;
  endfunction

  // One monitor step from the spec rules: the phase seen now comes from the
  // pattern applied one step earlier, impuls/clr from the current step.
  task automatic model_step(input logic [4:0] p, input bit imp, input bit clr);
    int np;
    bit chg, conf, seq, ty, tr;
    np   = phase_of(p);
    chg  = (np != m_phase);
    conf = (np == 3);
    seq  = chg && m_phase != 3 && np != 3 && np != (m_phase + 1) % 3;
    ty   = chg && m_phase == 1 && np == 2 && (m_secs < TY - TOL || m_secs > TY + TOL);
    tr   = chg && m_phase == 2 && np == 0 && (m_secs < TR - TOL || m_secs > TR + TOL);
    if (chg && m_phase == 2 && np == 0) m_cycles = (m_cycles + 1) % 65536;
    if (chg) m_secs = 0;
    else if (imp && m_secs < 255) m_secs = m_secs + 1;
    if (clr) begin
      m_conf = 0; m_seq = 0; m_tim = 0; m_code = 0;
    end
    if (conf) m_conf = 1;
    if (seq) m_seq = 1;
    if (ty || tr) m_tim = 1;
    if (m_code == 0) m_code = conf ? 1 : seq ? 2 : ty ? 3 : tr ? 4 : 0;
    m_phase = np;
  endtask

  task automatic compare_all();
    check("phase", int'(phase), m_phase);
    check("phase_secs", int'(phase_secs), m_secs);
    check("cycles", int'(cycles), m_cycles);
    check("err_conflict", int'(err_conflict), m_conf);
    check("err_sequence", int'(err_sequence), m_seq);
    check("err_timing", int'(err_timing), m_tim);
    check("err_code", int'(err_code), m_code);
  endtask

  task automatic cycle(input logic [4:0] pat, input bit imp, input bit clr);
    {red, yellow, green, redpieton, greenpieton} = pat;
    impuls  = imp;
    clr_err = clr;
    @(posedge clk);
    #1;
    model_step(pat_prev, imp, clr);
    pat_prev = pat;
    compare_all();
  endtask

  // Apply a pattern, let the phase change land with no tick, then give 'ticks' seconds.
  task automatic hold(input logic [4:0] pat, input int ticks);
    cycle(pat, 1'b0, 1'b0);
    cycle(pat, 1'b0, 1'b0);
    for (int i = 0; i < ticks; i++) cycle(pat, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    check("rst_phase", int'(phase), 0);
    check("rst_secs", int'(phase_secs), 0);
    check("rst_cycles", int'(cycles), 0);
    check("rst_flags", int'({err_conflict, err_sequence, err_timing}), 0);
    check("rst_code", int'(err_code), 0);
    m_phase = 0; m_secs = 0; m_cycles = 0;
    m_conf = 0; m_seq = 0; m_tim = 0; m_code = 0;
    pat_prev = PG;
    impuls = 1'b0;
    clr_err = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [4:0] pats [3];
    logic [4:0] pat;
    int cur, nxt, r, ticks;
    pats[0] = PG; pats[1] = PY; pats[2] = PR;
    {red, yellow, green, redpieton, greenpieton} = PG;
    impuls = 1'b0;
    clr_err = 1'b0;
    rst = 1'b0;
    #3;
    do_reset();

    // Legal full cycle
    hold(PY, 2); hold(PR, 10); hold(PG, 0);
    check("legal_cycles", int'(cycles), 1);
    check("legal_flags", int'({err_conflict, err_sequence, err_timing}), 0);
    check("legal_code", int'(err_code), 0);

    // Yellow too long
    do_reset();
    hold(PY, 4); hold(PR, 10);
    check("ylong_timing", int'(err_timing), 1);
    check("ylong_code", int'(err_code), 3);
    hold(PG, 0);
    check("ylong_cycles", int'(cycles), 1);

    // Illegal GREEN->RED, then conflict keeps the first code
    do_reset();
    hold(PR, 0);
    check("seq_flag", int'(err_sequence), 1);
    check("seq_code", int'(err_code), 2);
    hold(PCONF, 0);
    check("seq_conf_flag", int'(err_conflict), 1);
    check("seq_conf_code", int'(err_code), 2);

    // Saturation in GREEN, then tick coinciding with phase change
    do_reset();
    for (int i = 0; i < 300; i++) cycle(PG, 1'b1, 1'b0);
    check("sat_secs", int'(phase_secs), 255);
    cycle(PY, 1'b1, 1'b0);
    cycle(PY, 1'b1, 1'b0);
    check("tick_change_secs", int'(phase_secs), 0);
    check("tick_change_phase", int'(phase), 1);

    // Clear coinciding with a conflict, then a plain clear
    do_reset();
    cycle(PCONF, 1'b0, 1'b0);
    cycle(PCONF, 1'b0, 1'b1);
    check("clr_conf_flag", int'(err_conflict), 1);
    check("clr_conf_code", int'(err_code), 1);
    cycle(PG, 1'b0, 1'b0);
    cycle(PG, 1'b0, 1'b0);
    cycle(PG, 1'b0, 1'b1);
    check("clr_flags", int'({err_conflict, err_sequence, err_timing}), 0);
    check("clr_code", int'(err_code), 0);

    // Reset mid-RED discards timing history
    do_reset();
    hold(PY, 2);
    hold(PR, 6);
    check("midred_secs", int'(phase_secs), 6);
    do_reset();
    hold(PY, 2); hold(PR, 10); hold(PG, 0);
    check("post_rst_timing", int'(err_timing), 0);
    check("post_rst_cycles", int'(cycles), 1);

    // Randomized phase sequences with random ticks, conflicts and clears
    do_reset();
    cur = 0;
    for (int seg = 0; seg < 60; seg++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      nxt = (cur + 1) % 3;
      else if (r < 9) nxt = $urandom_range(0, 2);
      else            nxt = 3;
      pat = (nxt == 3) ? 5'($urandom_range(0, 31)) : pats[nxt];
      case (nxt)
        1:       ticks = $urandom_range(0, 4);
        2:       ticks = $urandom_range(7, 13);
        default: ticks = $urandom_range(0, 6);
      endcase
      cycle(pat, 1'($urandom_range(0, 1)), 1'b0);
      cycle(pat, 1'($urandom_range(0, 1)), 1'b0);
      for (int i = 0; i < ticks; i++)
        cycle(pat, 1'b1, ($urandom_range(0, 19) == 0));
      if (nxt != 3) cur = nxt;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/semafor_monitor.md
SEMAFOR_MONITOR -- requirements
Module: semafor_monitor

Interface
REQ-001 Parameter T_YELLOW, 2, required yellow-phase duration in seconds.
REQ-002 Parameter T_RED, 10, required vehicle-red duration in seconds.
REQ-003 Parameter TOL, 1, allowed +/- deviation in seconds for both timing checks.
REQ-004 clk  input  1  single clock; every register in the block is clocked on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 impuls  input  1  one-cycle 1-second tick, synchronous to clk.
REQ-007 red, yellow, green  input  1 each  vehicle lamps, active-low (0 = lit).
REQ-008 redpieton, greenpieton  input  1 each  pedestrian lamps, active-low.
REQ-009 clr_err  input  1  synchronous one-cycle pulse that clears the error state.
REQ-010 phase  output  2  decoded phase: 0 GREEN, 1 YELLOW, 2 RED, 3 INVALID.
REQ-011 phase_secs  output  8  whole seconds spent in the current phase, saturating at 255.
REQ-012 cycles  output  16  count of completed RED->GREEN transitions, wraps from 65535 to 0.
REQ-013 err_conflict, err_sequence, err_timing  output  1 each  sticky error flags.
REQ-014 err_code  output  3  first error since reset/clear: 0 none, 1 conflict, 2 sequence, 3 yellow timing, 4 red timing.

Function
REQ-015 All five lamp inputs SHALL be registered once; decode SHALL use only the registered copy.
REQ-016 Decode: GREEN = green lit, red and yellow dark, redpieton lit, greenpieton dark.
REQ-017 Decode: YELLOW = yellow lit, red and green dark, redpieton lit, greenpieton dark.
REQ-018 Decode: RED = red lit, green and yellow dark, greenpieton lit, redpieton dark.
REQ-019 Any other combination SHALL decode as INVALID, and err_conflict SHALL set.
REQ-020 phase SHALL update on the clock edge after the sample edge, giving 2 cycles of latency from a lamp change to phase and flags.
REQ-021 Legal transitions are GREEN->YELLOW, YELLOW->RED and RED->GREEN. Any other change between valid phases SHALL set err_sequence.
REQ-022 Entering INVALID or leaving INVALID to any valid phase SHALL NOT set err_sequence; the monitor resynchronises silently.
REQ-023 phase_secs SHALL clear to 0 on every phase change and otherwise increment on impuls, holding at 255.
REQ-024 If impuls and a phase change coincide, phase_secs SHALL load 0.
REQ-025 On YELLOW->RED, if phase_secs lies outside [T_YELLOW-TOL, T_YELLOW+TOL], err_timing SHALL set and the code SHALL be 3.
REQ-026 On RED->GREEN, if phase_secs lies outside [T_RED-TOL, T_RED+TOL], err_timing SHALL set and the code SHALL be 4.
REQ-027 Timing checks SHALL NOT run on a transition out of INVALID.
REQ-028 cycles SHALL increment on each legal RED->GREEN transition, regardless of timing errors.
REQ-029 err_code SHALL latch only while it equals 0. Priority for simultaneous errors: conflict > sequence > timing.
REQ-030 clr_err SHALL clear all three flags and err_code. An error detected in the same cycle SHALL win and be recorded as if it followed the clear.
REQ-031 GREEN with no activity SHALL be able to persist indefinitely without any error.

Reset
REQ-032 While rst = 0: all registers are cleared asynchronously.
REQ-033 Reset values: registered lamps = GREEN pattern (red=1, yellow=1, green=0, redpieton=0, greenpieton=1); phase = GREEN; phase_secs = 0; cycles = 0; flags = 0; err_code = 0.
REQ-034 Reset asserted mid-phase SHALL discard all timing history. The first phase seen after release SHALL be checked against the GREEN reset phase.

Structure
REQ-035 Shared package semafor_pkg SHALL hold the phase encoding, the err_code constants and the defaults T_RED=10, T_GREEN=5, T_YELLOW=2, T_DELAY=10, which the controller also uses.
REQ-036 One combinational sub-module, semafor_lamp_decode, SHALL map the 5 lamp bits to a phase. The checks, counters and error logic SHALL stay in semafor_monitor.

Verification
REQ-037 Legal cycle GREEN->YELLOW (2 ticks)->RED (10 ticks)->GREEN -> cycles=1, all flags 0, err_code=0.
REQ-038 Yellow held for 4 ticks -> err_timing=1 and err_code=3, 2 cycles after the RED pattern is applied; cycles still increments on the next RED->GREEN.
REQ-039 Apply GREEN then RED directly -> err_sequence=1, err_code=2; a following conflict pattern (green and greenpieton both lit) sets err_conflict=1 with err_code staying 2.
REQ-040 impuls and a phase change in the same cycle, plus 300 ticks held in GREEN -> phase_secs=0 after the change, then saturates at 255.
REQ-041 clr_err pulsed in the same cycle as a detected conflict -> err_conflict=1, err_code=1; a later clr_err alone -> all flags 0, err_code=0.
REQ-042 rst pulsed low mid-RED with phase_secs=6 -> all outputs return to reset values immediately; the next legal cycle produces no timing error.
